alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_W, default 19, datapath width; fixed at 19 for this release.
REQ-002 Parameter OP_W, default 5, ALU opcode width; matches the ALU's ALUControl port.
REQ-003 Port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  instruction offered.
REQ-006 Port in_instr  input  19  instruction: [18:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] unused; LDI uses [10:0] as imm11.
REQ-007 Port in_ready  output  1  sequencer accepts an instruction this cycle.
REQ-008 Port alu_a  output  19  ALU operand A.
REQ-009 Port alu_b  output  19  ALU operand B.
REQ-010 Port alu_ctrl  output  5  ALU operation select.
REQ-011 Port alu_result  input  19  ALU Result, combinational from alu_a/alu_b/alu_ctrl.
REQ-012 Port alu_negative  input  1  ALU Negative flag.
REQ-013 Port out_valid  output  1  completion response valid.
REQ-014 Port out_ready  input  1  consumer accepts the response.
REQ-015 Port out_result  output  19  value written to rd (0 on error).
REQ-016 Port out_negative  output  1  sticky N flag after this instruction.
REQ-017 Port out_error  output  1  illegal opcode flag for this response.
REQ-018 Port dbg_addr  input  3  register file debug read address.
REQ-019 Port dbg_data  output  19  combinational read of R[dbg_addr].

Function
REQ-020 Register file: 8 x 19 bits; R0 always reads 0; writes to R0 are discarded.
REQ-021 FSM states: IDLE, DECODE, EXEC, WB, RESP; in_ready = 1 only in IDLE.
REQ-022 IDLE -> DECODE on in_valid & in_ready; in_instr is latched into an internal instruction register on that edge; in_valid outside IDLE is ignored.
REQ-023 DECODE: alu_a <= R[rs1], alu_b <= R[rs2], alu_ctrl <= opcode (ALU opcodes only); next state EXEC.
REQ-024 EXEC: ALU inputs stable for the full cycle; alu_result and alu_negative are captured at the end of the cycle; next state WB.
REQ-025 WB: legal opcode -> R[rd] <= captured result and N flag <= captured negative; next state RESP.
REQ-026 RESP: out_valid = 1; out_result, out_negative and out_error are held stable until out_valid & out_ready; next state IDLE.
REQ-027 Latency: out_valid first rises exactly 4 cycles after the accepting edge; minimum issue interval is 5 cycles.
REQ-028 ALU opcodes 00000-01100 are legal and are passed through unchanged. This includes 01010-01100: the ALU returns 0, which is written normally.
REQ-029 Opcode 11111 (LDI): R[rd] <= {8'b0, imm11}; N <= 0; alu_* outputs are not updated.
REQ-030 Opcodes 01101-11110 are illegal: no register write, N unchanged, out_result = 0, out_error = 1.
REQ-031 Divide by zero: the ALU result (0) is written; out_error = 0.
REQ-032 Unary ops (INC, DEC, NOT) still drive alu_b = R[rs2], and the ALU ignores it.
REQ-033 rd == rs1 or rd == rs2: operands are read in DECODE, before the write in WB, so the old values are used.
REQ-034 alu_a, alu_b and alu_ctrl hold their last values outside DECODE/EXEC.

Reset
REQ-035 rst = 1 at a clock edge: state <= IDLE; all R[i] <= 0; N <= 0; alu_a, alu_b, alu_ctrl <= 0; out_valid, out_result, out_negative, out_error <= 0.
REQ-036 Reset in any state, including EXEC, WB or RESP, aborts the instruction: no register write and no response.
REQ-037 rst has priority over all other inputs; in_ready = 1 on the first cycle after rst is deasserted.

Verification
REQ-038 Issue LDI R1,5; LDI R2,3; ADD(00000) R3,R1,R2 -> out_result 19'd8, out_negative 0; out_valid exactly 4 cycles after the ADD is accepted.
REQ-039 Issue SUB(00001) R4,R2,R1 (3-5) -> out_result 19'h7FFFE, out_negative 1, dbg_data(R4) = 19'h7FFFE.
REQ-040 Issue DIV(00011) R5,R1,R0 -> out_result 0, out_error 0, R5 = 0; then issue opcode 01101 with rd=R1 -> out_error 1, R1 still 5, N unchanged.
REQ-041 Hold out_ready = 0 for 3 cycles in RESP -> out_valid and outputs stable, in_ready 0; a concurrent in_valid is dropped.
REQ-042 Assert rst during EXEC of ADD R6,R1,R2 -> no response, R6 = 0, in_ready = 1 on the next cycle after rst is deasserted.
REQ-043 Issue LDI R0,7 -> response out_result 7, but dbg_data(R0) = 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Five-state instruction sequencer driving an external combinational ALU.
// Holds an 8-entry register file, a sticky negative flag and a valid/ready response port.
module alu_sequencer #(
  parameter int DATA_W = 19,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_negative,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_negative,
  output logic              out_error,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [OP_W-1:0] OP_ALU_LAST = 5'd12;
  localparam logic [OP_W-1:0] OP_LDI      = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] instr_r;
  logic [DATA_W-1:0] rf_r [8];
  logic              n_r;
  logic [DATA_W-1:0] res_r;
  logic              neg_r;

  logic [OP_W-1:0]   opcode_s;
  logic [2:0]        rd_s;
  logic [2:0]        rs1_s;
  logic [2:0]        rs2_s;
  logic [10:0]       imm_s;
  logic              is_alu_s;
  logic              is_ldi_s;
  logic              wr_en_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              wb_neg_s;
  logic              wb_err_s;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op <= OP_ALU_LAST);
  endfunction

  // Instruction field extraction from the latched instruction.
  always_comb begin
    opcode_s = instr_r[18:14];
    rd_s     = instr_r[13:11];
    rs1_s    = instr_r[10:8];
    rs2_s    = instr_r[7:5];
    imm_s    = instr_r[10:0];
    is_alu_s = is_alu_op(opcode_s);
    is_ldi_s = (opcode_s == OP_LDI);
  end

  // Write-back value, flag and error selection for the current instruction.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = {DATA_W{1'b0}};
    wb_neg_s  = n_r;
    wb_err_s  = 1'b0;
    if (is_alu_s) begin
      wr_en_s   = 1'b1;
      wr_data_s = res_r;
      wb_neg_s  = neg_r;
    end else if (is_ldi_s) begin
      wr_en_s   = 1'b1;
      wr_data_s = {{(DATA_W-11){1'b0}}, imm_s};
      wb_neg_s  = 1'b0;
    end else begin
      wb_err_s  = 1'b1;
    end
  end

  assign in_ready = (state_r == S_IDLE);
  assign dbg_data = (dbg_addr == 3'd0) ? {DATA_W{1'b0}} : rf_r[dbg_addr];

  // Sequencer FSM, register file and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      instr_r      <= {DATA_W{1'b0}};
      n_r          <= 1'b0;
      res_r        <= {DATA_W{1'b0}};
      neg_r        <= 1'b0;
      alu_a        <= {DATA_W{1'b0}};
      alu_b        <= {DATA_W{1'b0}};
      alu_ctrl     <= {OP_W{1'b0}};
      out_valid    <= 1'b0;
      out_result   <= {DATA_W{1'b0}};
      out_negative <= 1'b0;
      out_error    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            instr_r <= in_instr;
            state_r <= S_DECODE;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_DECODE: begin
          // Operands are read here, before any write-back, so rd==rs sees old data.
          if (is_alu_s) begin
            alu_a    <= rf_r[rs1_s];
            alu_b    <= rf_r[rs2_s];
            alu_ctrl <= opcode_s;
          end
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          res_r   <= alu_result;
          neg_r   <= alu_negative;
          state_r <= S_WB;
        end
        S_WB: begin
          if (wr_en_s && (rd_s != 3'd0)) begin
            rf_r[rd_s] <= wr_data_s;
          end
          n_r          <= wb_neg_s;
          out_result   <= wr_data_s;
          out_negative <= wb_neg_s;
          out_error    <= wb_err_s;
          out_valid    <= 1'b1;
          state_r      <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= S_IDLE;
          end else begin
            state_r   <= S_RESP;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer with a behavioural ALU and
// an architectural reference model (register array plus N flag).
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [18:0] in_instr;
  logic        in_ready;
  logic [18:0] alu_a;
  logic [18:0] alu_b;
  logic [4:0]  alu_ctrl;
  logic [18:0] alu_result;
  logic        alu_negative;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_result;
  logic        out_negative;
  logic        out_error;
  logic [2:0]  dbg_addr;
  logic [18:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  logic [18:0] m_rf [8];
  logic        m_n;

  alu_sequencer #(.DATA_W(19), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_negative(alu_negative), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_negative(out_negative), .out_error(out_error),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 INC, 9 DEC, else 0.
  function automatic logic [18:0] alu_fn(input logic [4:0] op, input logic [18:0] a, input logic [18:0] b);
    case (op)
      5'd0: return 19'(a + b);
      5'd1: return 19'(a - b);
      5'd2: return 19'(a * b);
      5'd3: return (b == 19'd0) ? 19'd0 : 19'(a / b);
      5'd4: return a & b;
      5'd5: return a | b;
      5'd6: return a ^ b;
      5'd7: return ~a;
      5'd8: return 19'(a + 19'd1);
      5'd9: return 19'(a - 19'd1);
      default: return 19'd0;
    endcase
  endfunction

  always_comb begin
    alu_result   = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_negative = alu_result[18];
  end

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 19'd0;
    m_n = 1'b0;
  endfunction

  // Architectural effect of one instruction; returns the expected response.
  function automatic void model_exec(input logic [18:0] ins, output logic [18:0] r,
                                     output logic ng, output logic er);
    logic [4:0] op;
    logic [2:0] rd;
    op = ins[18:14];
    rd = ins[13:11];
    if (op <= 5'd12) begin
      r = alu_fn(op, m_rf[ins[10:8]], m_rf[ins[7:5]]);
      ng = r[18]; er = 1'b0; m_n = ng;
      if (rd != 3'd0) m_rf[rd] = r;
    end else if (op == 5'd31) begin
      r = {8'd0, ins[10:0]};
      ng = 1'b0; er = 1'b0; m_n = 1'b0;
      if (rd != 3'd0) m_rf[rd] = r;
    end else begin
      r = 19'd0; ng = m_n; er = 1'b1;
    end
  endfunction

  function automatic logic [18:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 5'd0};
  endfunction

  function automatic logic [18:0] mk_ldi(input logic [2:0] rd, input logic [10:0] imm);
    return {5'd31, rd, imm};
  endfunction

  // Offers one instruction, waits for the response (bounded) and lets it handshake.
  task automatic issue(input logic [18:0] ins, output logic [18:0] r, output logic ng,
                       output logic er, output int lat, output time t_acc);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_in_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = 19'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = out_result; ng = out_negative; er = out_error;
    @(posedge clk);
  endtask

  task automatic check_resp(input string name, input logic [18:0] r, input logic ng, input logic er,
                            input int lat, input logic [18:0] er_r, input logic er_ng, input logic er_er);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d want 4", name, lat);
    end
    vectors++;
    if ({r, ng, er} !== {er_r, er_ng, er_er}) begin
      miscompares++;
      $display("FAIL %s_resp: got res=%h n=%b err=%b want res=%h n=%b err=%b",
               name, r, ng, er, er_r, er_ng, er_er);
    end
  endtask

  task automatic check_dbg(input string name, input logic [2:0] a, input logic [18:0] want);
    dbg_addr = a;
    #1;
    vectors++;
    if (dbg_data !== want) begin
      miscompares++;
      $display("FAIL %s_dbg R%0d: got %h want %h", name, a, dbg_data, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = 19'd0; out_ready = 1'b1; dbg_addr = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, out_result, out_negative, out_error, alu_a, alu_b, alu_ctrl} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b r=%h n=%b e=%b a=%h b=%h c=%h want all 0",
               out_valid, out_result, out_negative, out_error, alu_a, alu_b, alu_ctrl);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 8; i++) check_dbg("reset", 3'(i), 19'd0);
    model_reset();
  endtask

  task automatic test_directed();
    logic [18:0] r, mr; logic ng, er, mng, mer; int lat; time t;
    issue(mk_ldi(3'd1, 11'd5), r, ng, er, lat, t); model_exec(mk_ldi(3'd1, 11'd5), mr, mng, mer);
    check_resp("ldi_r1", r, ng, er, lat, 19'd5, 1'b0, 1'b0);
    issue(mk_ldi(3'd2, 11'd3), r, ng, er, lat, t); model_exec(mk_ldi(3'd2, 11'd3), mr, mng, mer);
    issue(mk(5'd0, 3'd3, 3'd1, 3'd2), r, ng, er, lat, t); model_exec(mk(5'd0, 3'd3, 3'd1, 3'd2), mr, mng, mer);
    check_resp("add", r, ng, er, lat, 19'd8, 1'b0, 1'b0);
    issue(mk(5'd1, 3'd4, 3'd2, 3'd1), r, ng, er, lat, t); model_exec(mk(5'd1, 3'd4, 3'd2, 3'd1), mr, mng, mer);
    check_resp("sub", r, ng, er, lat, 19'h7FFFE, 1'b1, 1'b0);
    check_dbg("sub", 3'd4, 19'h7FFFE);
    issue(mk(5'd3, 3'd5, 3'd1, 3'd0), r, ng, er, lat, t); model_exec(mk(5'd3, 3'd5, 3'd1, 3'd0), mr, mng, mer);
    check_resp("div0", r, ng, er, lat, 19'd0, 1'b0, 1'b0);
    check_dbg("div0", 3'd5, 19'd0);
    issue(mk(5'd13, 3'd1, 3'd2, 3'd3), r, ng, er, lat, t); model_exec(mk(5'd13, 3'd1, 3'd2, 3'd3), mr, mng, mer);
    check_resp("illegal", r, ng, er, lat, 19'd0, 1'b0, 1'b1);
    check_dbg("illegal", 3'd1, 19'd5);
    issue(mk_ldi(3'd0, 11'd7), r, ng, er, lat, t); model_exec(mk_ldi(3'd0, 11'd7), mr, mng, mer);
    check_resp("ldi_r0", r, ng, er, lat, 19'd7, 1'b0, 1'b0);
    check_dbg("ldi_r0", 3'd0, 19'd0);
    // Neither the illegal opcode nor LDI may disturb the ALU control left by DIV.
    vectors++;
    if (alu_ctrl !== 5'd3) begin
      miscompares++;
      $display("FAIL alu_ctrl_hold: got %h want 03", alu_ctrl);
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] snap_r, mr; logic snap_n, snap_e, mng, mer; int w;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = mk(5'd0, 3'd7, 3'd1, 3'd2);
    @(posedge clk);
    model_exec(mk(5'd0, 3'd7, 3'd1, 3'd2), mr, mng, mer);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    snap_r = out_result; snap_n = out_negative; snap_e = out_error;
    vectors++;
    if ({snap_r, snap_n, snap_e} !== {mr, mng, mer}) begin
      miscompares++;
      $display("FAIL stall_resp: got %h/%b/%b want %h/%b/%b", snap_r, snap_n, snap_e, mr, mng, mer);
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_instr = mk_ldi(3'd1, 11'h7FF);
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready, out_result, out_negative, out_error} !== {1'b1, 1'b0, snap_r, snap_n, snap_e}) begin
        miscompares++;
        $display("FAIL stall_hold cyc%0d: got v=%b rdy=%b %h/%b/%b want v=1 rdy=0 %h/%b/%b",
                 k, out_valid, in_ready, out_result, out_negative, out_error, snap_r, snap_n, snap_e);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    check_dbg("stall_drop", 3'd1, m_rf[1]);
  endtask

  task automatic test_back_to_back();
    logic [18:0] r, mr; logic ng, er, mng, mer; int lat; time t0, t1;
    logic [18:0] i0, i1;
    i0 = mk(5'd8, 3'd6, 3'd1, 3'd1);
    i1 = mk(5'd2, 3'd6, 3'd6, 3'd2);
    issue(i0, r, ng, er, lat, t0); model_exec(i0, mr, mng, mer);
    check_resp("b2b_inc", r, ng, er, lat, mr, mng, mer);
    issue(i1, r, ng, er, lat, t1); model_exec(i1, mr, mng, mer);
    check_resp("b2b_mul_rd_eq_rs", r, ng, er, lat, mr, mng, mer);
    vectors++;
    if (t1 - t0 !== 50) begin
      miscompares++;
      $display("FAIL b2b_interval: got %0t want 50", t1 - t0);
    end
  endtask

  task automatic test_reset_exec();
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = mk(5'd0, 3'd6, 3'd1, 3'd2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
        miscompares++;
        $display("FAIL rst_exec cyc%0d: got v=%b rdy=%b want v=0 rdy=1", k, out_valid, in_ready);
      end
    end
    check_dbg("rst_exec", 3'd6, 19'd0);
    check_dbg("rst_exec", 3'd1, 19'd0);
  endtask

  task automatic test_random();
    logic [18:0] ins, r, mr; logic ng, er, mng, mer; int lat; time t; logic [4:0] op;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      ins = {op, 14'($urandom)};
      issue(ins, r, ng, er, lat, t);
      model_exec(ins, mr, mng, mer);
      check_resp("random", r, ng, er, lat, mr, mng, mer);
      check_dbg("random", ins[13:11], m_rf[ins[13:11]]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
